// File: rtl/sram_fifo_ctrl.sv
// Controller for an attached BRAM FIFO macro: runs a PRE/RST/POST reset sequence
// before allowing transfers, tracks occupancy and flags rejected push/pop requests.
module sram_fifo_ctrl #(
   parameter  int DEPTH       = 1024,
   parameter  int PRE_CYCLES  = 4,
   parameter  int RST_CYCLES  = 5,
   parameter  int POST_CYCLES = 4,
   localparam int UW          = $clog2(DEPTH + 1)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          flush_i,
   input  logic          push_i,
   input  logic          pop_i,
   output logic          fifo_rst_o,
   output logic          fifo_wren_o,
   output logic          fifo_rden_o,
   output logic          ready_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [UW-1:0] usage_o,
   output logic          wr_err_o,
   output logic          rd_err_o
);

   localparam int MAX_AB = (PRE_CYCLES > RST_CYCLES) ? PRE_CYCLES : RST_CYCLES;
   localparam int MAXC   = (MAX_AB > POST_CYCLES) ? MAX_AB : POST_CYCLES;
   localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;

   typedef enum logic [1:0] {
      ST_PRE   = 2'd0,
      ST_RST   = 2'd1,
      ST_POST  = 2'd2,
      ST_READY = 2'd3
   } state_t;

   state_t          state_reg, state_next;
   logic [CW-1:0]   cnt_reg, cnt_next;
   logic [UW-1:0]   usage_reg, usage_next;
   logic            wr_err_reg, wr_err_next;
   logic            rd_err_reg, rd_err_next;
   logic            push_acc, pop_acc;
   logic            is_full, is_empty, is_ready;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg  <= ST_PRE;
         cnt_reg    <= '0;
         usage_reg  <= '0;
         wr_err_reg <= 1'b0;
         rd_err_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         usage_reg  <= usage_next;
         wr_err_reg <= wr_err_next;
         rd_err_reg <= rd_err_next;
      end
   end

   assign is_ready = (state_reg == ST_READY);
   assign is_full  = (usage_reg == UW'(DEPTH));
   assign is_empty = (usage_reg == '0);

   // A flush or reset in the same cycle wins over any transfer.
   assign push_acc = push_i & is_ready & ~is_full  & ~flush_i & ~rst_i;
   assign pop_acc  = pop_i  & is_ready & ~is_empty & ~flush_i & ~rst_i;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg + 1'b1;
      case (state_reg)
         ST_PRE: begin
            if (flush_i) begin
               cnt_next = '0;
            end else if (cnt_reg == CW'(PRE_CYCLES - 1)) begin
               state_next = ST_RST;
               cnt_next   = '0;
            end
         end
         ST_RST: begin
            if (cnt_reg == CW'(RST_CYCLES - 1)) begin
               state_next = ST_POST;
               cnt_next   = '0;
            end
         end
         ST_POST: begin
            if (flush_i) begin
               state_next = ST_PRE;
               cnt_next   = '0;
            end else if (cnt_reg == CW'(POST_CYCLES - 1)) begin
               state_next = ST_READY;
               cnt_next   = '0;
            end
         end
         default: begin
            cnt_next = '0;
            if (flush_i) begin
               state_next = ST_PRE;
            end
         end
      endcase
   end

   always_comb begin
      usage_next = '0;
      if (is_ready && !flush_i) begin
         usage_next = usage_reg + UW'(push_acc) - UW'(pop_acc);
      end
   end

   assign wr_err_next = push_i & ~push_acc;
   assign rd_err_next = pop_i  & ~pop_acc;

   assign fifo_rst_o  = (state_reg == ST_RST);
   assign fifo_wren_o = push_acc;
   assign fifo_rden_o = pop_acc;
   assign ready_o     = is_ready;
   assign full_o      = is_full;
   assign empty_o     = is_empty;
   assign usage_o     = usage_reg;
   assign wr_err_o    = wr_err_reg;
   assign rd_err_o    = rd_err_reg;

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Bench for sram_fifo_ctrl: directed bring-up/flush/reset scenarios plus random
// traffic, every cycle compared against a timeline-based reference model.
module tb_sram_fifo_ctrl;

   localparam int DEPTH = 1024;
   localparam int PRE   = 4;
   localparam int RSTC  = 5;
   localparam int POST  = 4;
   localparam int TOT   = PRE + RSTC + POST;
   localparam int UW    = $clog2(DEPTH + 1);

   logic          clk_i = 1'b0;
   logic          rst_i, flush_i, push_i, pop_i;
   logic          fifo_rst_o, fifo_wren_o, fifo_rden_o, ready_o;
   logic          full_o, empty_o, wr_err_o, rd_err_o;
   logic [UW-1:0] usage_o;

   sram_fifo_ctrl #(
      .DEPTH(DEPTH), .PRE_CYCLES(PRE), .RST_CYCLES(RSTC), .POST_CYCLES(POST)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .push_i(push_i), .pop_i(pop_i),
      .fifo_rst_o(fifo_rst_o), .fifo_wren_o(fifo_wren_o), .fifo_rden_o(fifo_rden_o),
      .ready_o(ready_o), .full_o(full_o), .empty_o(empty_o), .usage_o(usage_o),
      .wr_err_o(wr_err_o), .rd_err_o(rd_err_o)
   );

   always #5 clk_i = ~clk_i;

   int errors = 0;
   int checks = 0;

   // Model: time since the sequence started (saturates at TOT = ready), occupancy.
   int t = 0;
   int usage = 0;
   bit exp_wr_err = 0, exp_rd_err = 0;

   int cnt_frst, cnt_notready, cnt_wren, cnt_rden, cnt_wrerr, cnt_rderr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic clr_counts();
      cnt_frst = 0; cnt_notready = 0; cnt_wren = 0;
      cnt_rden = 0; cnt_wrerr = 0; cnt_rderr = 0;
   endtask

   // One clock cycle: drive at the falling edge, compare, then advance the model.
   task automatic do_cycle(input bit r, input bit f, input bit pu, input bit po);
      bit rdy, frst, full, empty, aw, ar;
      rst_i = r; flush_i = f; push_i = pu; pop_i = po;
      #1;
      rdy   = (t >= TOT);
      frst  = (t >= PRE) && (t < PRE + RSTC);
      full  = (usage == DEPTH);
      empty = (usage == 0);
      aw    = pu && rdy && !full  && !f && !r;
      ar    = po && rdy && !empty && !f && !r;
      chk("ready",    32'(ready_o),     32'(rdy));
      chk("fifo_rst", 32'(fifo_rst_o),  32'(frst));
      chk("wren",     32'(fifo_wren_o), 32'(aw));
      chk("rden",     32'(fifo_rden_o), 32'(ar));
      chk("usage",    32'(usage_o),     32'(usage));
      chk("full",     32'(full_o),      32'(full));
      chk("empty",    32'(empty_o),     32'(empty));
      chk("wr_err",   32'(wr_err_o),    32'(exp_wr_err));
      chk("rd_err",   32'(rd_err_o),    32'(exp_rd_err));
      cnt_frst     += int'(fifo_rst_o);
      cnt_notready += int'(!ready_o);
      cnt_wren     += int'(fifo_wren_o);
      cnt_rden     += int'(fifo_rden_o);
      cnt_wrerr    += int'(wr_err_o);
      cnt_rderr    += int'(rd_err_o);
      @(posedge clk_i);
      if (r) begin
         t = 0; usage = 0; exp_wr_err = 0; exp_rd_err = 0;
      end else begin
         exp_wr_err = pu && !aw;
         exp_rd_err = po && !ar;
         if (rdy) begin
            if (f) begin t = 0; usage = 0; end
            else usage = usage + int'(aw) - int'(ar);
         end else if (frst) begin
            t++;
         end else if (f) begin
            t = 0;
         end else begin
            t++;
         end
      end
      @(negedge clk_i);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 0);
   endtask

   task automatic wait_ready();
      int n = 0;
      while (ready_o !== 1'b1 && n < 100) begin
         do_cycle(0, 0, 0, 0);
         n++;
      end
      chk("wait_ready", 32'(ready_o), 32'd1);
   endtask

   initial begin
      int first_frst, first_ready;
      rst_i = 1; flush_i = 0; push_i = 0; pop_i = 0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);

      // Reset state, with requests ignored while reset is held.
      do_cycle(1, 0, 0, 0);
      do_cycle(1, 1, 1, 1);
      $display("reset: ready=%0d empty=%0d full=%0d", ready_o, empty_o, full_o);

      // Bring-up timeline: request noise must not enable anything before READY.
      clr_counts();
      first_frst = -1; first_ready = -1;
      for (int k = 0; k <= 13; k++) begin
         if (fifo_rst_o === 1'b1 && first_frst < 0) first_frst = k;
         if (ready_o === 1'b1 && first_ready < 0) first_ready = k;
         if (k < 13) do_cycle(0, 0, 1'($urandom), 1'($urandom));
         else        do_cycle(0, 0, 0, 0);
      end
      chk("bringup_first_frst", 32'(first_frst), 32'd4);
      chk("bringup_frst_len", 32'(cnt_frst), 32'd5);
      chk("bringup_first_ready", 32'(first_ready), 32'd13);
      chk("bringup_no_enables", 32'(cnt_wren + cnt_rden), 32'd0);
      $display("bringup: fifo_rst from %0d for %0d, ready at %0d", first_frst, cnt_frst, first_ready);

      // Empty with simultaneous push and pop.
      do_cycle(0, 0, 1, 1);
      do_cycle(0, 0, 0, 0);
      chk("empty_pushpop_usage", 32'(usage_o), 32'd1);
      $display("empty push+pop: usage=%0d", usage_o);

      // Fill to full with 1030 consecutive pushes.
      do_cycle(0, 1, 0, 0);
      wait_ready();
      clr_counts();
      for (int i = 0; i < 1030; i++) do_cycle(0, 0, 1, 0);
      do_cycle(0, 0, 0, 0);
      chk("fill_usage", 32'(usage_o), 32'(DEPTH));
      chk("fill_full", 32'(full_o), 32'd1);
      chk("fill_wren_count", 32'(cnt_wren), 32'd1024);
      chk("fill_wrerr_count", 32'(cnt_wrerr), 32'd6);
      $display("fill: usage=%0d wren=%0d wr_err=%0d", usage_o, cnt_wren, cnt_wrerr);

      // Full with simultaneous push and pop.
      do_cycle(0, 0, 1, 1);
      chk("full_pushpop_usage", 32'(usage_o), 32'(DEPTH - 1));
      $display("full push+pop: usage=%0d", usage_o);

      // Flush from usage 37.
      do_cycle(0, 1, 0, 0);
      wait_ready();
      for (int i = 0; i < 37; i++) do_cycle(0, 0, 1, 0);
      chk("flush_pre_usage", 32'(usage_o), 32'd37);
      do_cycle(0, 1, 1, 1);
      chk("flush_usage_zero", 32'(usage_o), 32'd0);
      clr_counts();
      idle(20);
      chk("flush_notready", 32'(cnt_notready), 32'd13);
      chk("flush_frst_len", 32'(cnt_frst), 32'd5);
      chk("flush_ready_empty", 32'(ready_o & empty_o), 32'd1);
      $display("flush: notready=%0d fifo_rst=%0d", cnt_notready, cnt_frst);

      // Flush during POST restarts the whole sequence.
      do_cycle(0, 1, 0, 0);
      idle(PRE + RSTC + 2);
      do_cycle(0, 1, 0, 0);
      clr_counts();
      idle(20);
      chk("postflush_notready", 32'(cnt_notready), 32'd13);
      chk("postflush_frst_len", 32'(cnt_frst), 32'd5);
      $display("post flush: notready=%0d fifo_rst=%0d", cnt_notready, cnt_frst);

      // Reset while the macro reset is active aborts it at once.
      do_cycle(0, 1, 0, 0);
      idle(PRE + 2);
      chk("rst_in_rst_pre", 32'(fifo_rst_o), 32'd1);
      do_cycle(1, 0, 0, 0);
      chk("rst_in_rst_drop", 32'(fifo_rst_o), 32'd0);
      do_cycle(1, 0, 0, 0);
      clr_counts();
      idle(20);
      chk("rst_replay_notready", 32'(cnt_notready), 32'd13);
      chk("rst_replay_frst_len", 32'(cnt_frst), 32'd5);
      $display("reset in RST: replay notready=%0d fifo_rst=%0d", cnt_notready, cnt_frst);

      // Random traffic with occasional flush and reset.
      clr_counts();
      for (int i = 0; i < 3000; i++) begin
         do_cycle(($urandom_range(399) == 0), ($urandom_range(149) == 0),
                  ($urandom_range(9) < 6), ($urandom_range(9) < 5));
      end
      $display("random: wren=%0d rden=%0d wr_err=%0d rd_err=%0d", cnt_wren, cnt_rden, cnt_wrerr, cnt_rderr);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sram_fifo_ctrl.md
SRAM_FIFO_CTRL -- requirements
Module: sram_fifo_ctrl

Interface
REQ-001 Parameter DEPTH, default 1024: entry count of the attached BRAM FIFO macro.
REQ-002 Parameter PRE_CYCLES, default 4: idle cycles with enables low before the macro reset.
REQ-003 Parameter RST_CYCLES, default 5: cycles the macro reset is held high.
REQ-004 Parameter POST_CYCLES, default 4: idle cycles with enables low after the macro reset.
REQ-005 Derived UW = $clog2(DEPTH+1); not overridable.
REQ-006 clk_i  in  1  single clock; all state updates on rising edge.
REQ-007 rst_i  in  1  reset, synchronous, active-high.
REQ-008 flush_i  in  1  request to empty FIFO via full reset sequence.
REQ-009 push_i  in  1  requester write request.
REQ-010 pop_i  in  1  requester read request.
REQ-011 fifo_rst_o  out  1  reset to BRAM FIFO macro.
REQ-012 fifo_wren_o  out  1  write enable to macro.
REQ-013 fifo_rden_o  out  1  read enable to macro.
REQ-014 ready_o  out  1  controller in READY, transfers allowed.
REQ-015 full_o / empty_o  out  1 each  occupancy flags from internal count.
REQ-016 usage_o  out  UW  current entry count.
REQ-017 wr_err_o / rd_err_o  out  1 each  single-cycle pulse on rejected push / pop.

Function
REQ-018 States: PRE, RST, POST, READY; one sequence counter shared by PRE/RST/POST, cleared on each state entry.
REQ-019 PRE -> RST after PRE_CYCLES cycles; RST -> POST after RST_CYCLES; POST -> READY after POST_CYCLES; READY holds until flush_i or rst_i.
REQ-020 fifo_rst_o = 1 exactly while state is RST (Moore, registered state decode, no glitch).
REQ-021 ready_o = 1 exactly while state is READY.
REQ-022 Push accepted = push_i & ready_o & ~full_o; fifo_wren_o = push accepted (combinational, same cycle).
REQ-023 Pop accepted = pop_i & ready_o & ~empty_o; fifo_rden_o = pop accepted (combinational, same cycle).
REQ-024 fifo_wren_o and fifo_rden_o are 0 in PRE, RST, POST regardless of inputs.
REQ-025 usage_o next = usage_o + push accepted - pop accepted; both accepted -> unchanged.
REQ-026 Empty with push and pop same cycle: push accepted, pop rejected (no fall-through), usage 0 -> 1.
REQ-027 Full with push and pop same cycle: pop accepted, push rejected, usage DEPTH -> DEPTH-1.
REQ-028 empty_o = (usage_o == 0); full_o = (usage_o == DEPTH); never both 1.
REQ-029 wr_err_o pulses (registered, 1 cycle later) for each cycle push_i=1 and push not accepted; rd_err_o likewise for pop_i.
REQ-030 flush_i in READY: next state PRE, usage_o -> 0 next cycle; push/pop in that cycle rejected with error pulses.
REQ-031 flush_i in PRE or POST restarts the sequence at PRE with counter 0; flush_i in RST ignored.
REQ-032 usage_o forced to 0 while not in READY.

Reset
REQ-033 rst_i high: next state PRE, counter 0, usage_o 0, wr_err_o 0, rd_err_o 0; overrides flush_i and all transfers.
REQ-034 Output values during and directly after reset: fifo_rst_o 0, fifo_wren_o 0, fifo_rden_o 0, ready_o 0, empty_o 1, full_o 0.
REQ-035 rst_i asserted mid-sequence or in READY aborts immediately; full sequence replays from PRE after release.

Verification
REQ-036 Defaults, rst_i released before edge 0 -> fifo_rst_o high edges 4..8 (5 cycles), ready_o first high at edge 13, enables 0 throughout edges 0..12.
REQ-037 READY, push_i every cycle 1030 cycles -> usage_o reaches 1024 and full_o=1, 6 wr_err_o pulses, fifo_wren_o pulses exactly 1024.
REQ-038 READY, usage 0, push_i=pop_i=1 one cycle -> wren 1, rden 0, usage 1, rd_err_o pulse next cycle.
REQ-039 READY usage 37, flush_i one cycle -> usage 0, ready_o low 13 cycles, fifo_rst_o high 5 cycles, then READY with empty_o=1.
REQ-040 flush_i at cycle 2 of POST -> sequence restarts at PRE; second fifo_rst_o window 5 cycles; ready_o delayed accordingly.
REQ-041 rst_i during RST state -> fifo_rst_o drops next cycle, full PRE/RST/POST replay after release.
